// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner (keypad_scan, keypad_debounce).
package keypad_pkg;
  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned NKEYS = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, HELD, LOCK} kp_state_t;

  function automatic logic [4:0] popcount(input logic [NKEYS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned i = 0; i < NKEYS; i++) n = n + {4'b0000, v[i]};
    return n;
  endfunction

  // Lowest pressed key index; only meaningful when exactly one bit is set.
  function automatic logic [3:0] encode(input logic [NKEYS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = NKEYS; i > 0; i--) if (v[i-1]) c = 4'(i - 1);
    return c;
  endfunction

  function automatic logic [3:0] irq_mask(input logic [3:0] code);
    return (code[3:2] == 2'b00) ? (4'b0001 << code[1:0]) : 4'b0000;
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Full-scan debouncer: the stable image follows the snapshot only after
// DEBOUNCE_SCANS consecutive identical scans, with a 1-cycle update strobe.
module keypad_debounce import keypad_pkg::*; #(
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snap_valid,
  input  logic [NKEYS-1:0] snapshot,
  output logic [NKEYS-1:0] stable,
  output logic             stable_upd
);
  localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);

  logic [NKEYS-1:0] prev;
  logic [SW-1:0]    stab_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      stab_cnt   <= '0;
      stable     <= '0;
      stable_upd <= 1'b0;
    end else begin
      stable_upd <= 1'b0;
      if (snap_valid) begin
        prev <= snapshot;
        if (snapshot != prev) begin
          stab_cnt <= '0;
        end else if (stab_cnt != SW'(DEBOUNCE_SCANS)) begin
          stab_cnt <= stab_cnt + 1'b1;
          if (stab_cnt == SW'(DEBOUNCE_SCANS - 1)) begin
            stable     <= snapshot;
            stable_upd <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: synchronizer, row scan, debounce, single-key event FSM.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan import keypad_pkg::*; #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 20,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  output logic            key_valid,
  output logic [3:0]      key_code,
  output logic [3:0]      key_irq,
  output logic            key_held
);
  localparam int unsigned DW = $clog2(SCAN_DIV);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scan: invalid parameter set");
  end

  logic [COLS-1:0]  col_s1, col_s2, col_pressed;
  logic [DW-1:0]    dwell;
  logic [1:0]       row_idx;
  logic [NKEYS-1:0] raw, snapshot, stable;
  logic             row_end, scan_done, stable_upd;
  kp_state_t        state_q, state_d;
  logic             new_press, emit, rep_fire;
  logic [3:0]       evt_code;

  assign col_pressed = ~col_s2;
  assign row         = ~(4'b0001 << row_idx);
  assign row_end     = (dwell == DW'(SCAN_DIV - 1));
  assign scan_done   = row_end && (row_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1  <= '1;
      col_s2  <= '1;
      dwell   <= '0;
      row_idx <= '0;
      raw     <= '0;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
      if (row_end) begin
        dwell                          <= '0;
        row_idx                        <= row_idx + 1'b1;
        raw[{row_idx, 2'b00} +: COLS]  <= col_pressed;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Row 3 is still being sampled on scan_done, so splice it in combinationally.
  always_comb begin
    snapshot                      = raw;
    snapshot[NKEYS-COLS +: COLS]  = col_pressed;
  end

  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .snap_valid (scan_done),
    .snapshot   (snapshot),
    .stable     (stable),
    .stable_upd (stable_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // In HELD, key_code still names the held key, so it doubles as the held image.
  always_comb begin
    state_d   = state_q;
    new_press = 1'b0;
    if (stable_upd) begin
      unique case (state_q)
        IDLE: begin
          if (popcount(stable) == 5'd1) begin
            state_d   = HELD;
            new_press = 1'b1;
          end else if (stable != '0) begin
            state_d = LOCK;
          end
        end
        HELD: begin
          if (stable == '0)                                state_d = IDLE;
          else if (stable != (NKEYS'(1) << key_code))      state_d = LOCK;
        end
        LOCK: if (stable == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first, rep_hit;

  assign rep_hit  = rep_first ? (rep_cnt == RW'(REPEAT_DELAY - 1)) : (rep_cnt == RW'(REPEAT_RATE - 1));
  assign rep_fire = (state_q == HELD) && scan_done && rep_hit;

  always_ff @(posedge clk) begin
    if (rst || state_q != HELD) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (scan_done) begin
      if (rep_hit) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign emit     = new_press || rep_fire;
  assign evt_code = new_press ? encode(stable) : key_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_irq   <= '0;
    end else begin
      key_valid <= emit;
      key_irq   <= emit ? irq_mask(evt_code) : 4'b0000;
      if (emit) key_code <= evt_code;
    end
  end

  assign key_held = (state_q == HELD);
endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a scan-level keypad/debounce model predicts events,
// a negedge monitor pops and compares them against key_valid/key_code/key_irq.
module tb_keypad_scan;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int RD       = 6;
  localparam int RR       = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col, row, key_code, key_irq;
  logic        key_valid, key_held;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad   = 0;
  int sb[$];

  int          m_state, m_run, m_n, m_code;
  logic [15:0] m_prev, m_img;

  keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_irq   (key_irq),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row line to its column line.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) if (!row[r]) col = col & ~pressed[r*4 +: 4];
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_n = 0; m_code = 0;
    m_prev = '0; m_img = '0;
  endtask

  // States: 0 idle, 1 one key held, 2 locked out.
  task automatic apply_stable(input logic [15:0] s);
    int k;
    k = $countones(s);
    case (m_state)
      0: begin
        if (k == 1) begin
          for (int i = 15; i >= 0; i--) if (s[i]) m_code = i;
          sb.push_back(m_code);
          m_state = 1;
          m_n     = 0;
        end else if (k >= 2) begin
          m_state = 2;
        end
      end
      1: begin
        if (k == 0)           m_state = 0;
        else if (s != m_img)  m_state = 2;
      end
      default: if (k == 0) m_state = 0;
    endcase
    m_img = s;
  endtask

  task automatic model_scan(input logic [15:0] s);
`ifdef KEYPAD_REPEAT_EN
    if (m_state == 1) begin
      m_n++;
      if (m_n >= RD && (m_n - RD) % RR == 0) sb.push_back(m_code);
    end
`endif
    if (s != m_prev) begin
      m_run = 0;
    end else if (m_run < DEB) begin
      m_run++;
      if (m_run == DEB) apply_stable(s);
    end
    m_prev = s;
  endtask

  // Called at the first negedge of row 0; returns at the first negedge of the next scan.
  task automatic do_scan(input logic [15:0] s);
    int         exp_h;
    logic [3:0] er;
    exp_h   = (m_state == 1) ? 1 : 0;
    pressed = s;
    model_scan(s);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 2) check("key_held", int'(key_held), exp_h);
      if (i % 4 == 0) begin
        er = ~(4'b0001 << ((i / 4) % 4));
        check("row", int'(row), int'(er));
      end
    end
  endtask

  task automatic reset_checks();
    check("rst_row", int'(row), 14);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_irq", int'(key_irq), 0);
    check("rst_key_held", int'(key_held), 0);
  endtask

  task automatic do_reset();
    repeat (2) @(negedge clk);
    check("events_pending_at_reset", sb.size(), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    int exp;
    if (key_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_event: got key_code=%0d expected no event at %0t", key_code, $time);
      end else begin
        exp = sb.pop_front();
        check("key_code", int'(key_code), exp);
        check("key_irq", int'(key_irq), (exp < 4) ? (1 << exp) : 0);
      end
    end else begin
      check("key_irq_idle", int'(key_irq), 0);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks();
    rst = 1'b0;

    repeat (4)  do_scan('0);
    repeat (10) do_scan(16'h0020);               // key 5
    repeat (6)  do_scan('0);
    repeat (6)  do_scan(16'h0004);               // key 2
    repeat (5)  do_scan('0);
    do_scan(16'h0001); do_scan('0); do_scan(16'h0001); do_scan('0);
    repeat (6)  do_scan(16'h0001);               // key 0 after bounce
    repeat (5)  do_scan('0);
    repeat (5)  do_scan(16'h0081);               // keys 0+7: lockout
    repeat (5)  do_scan(16'h0001);
    repeat (5)  do_scan('0);
    repeat (6)  do_scan(16'h0008);               // key 3
    repeat (5)  do_scan('0);
    repeat (DEB + 20) do_scan(16'h0200);         // key 9 long hold
    repeat (5)  do_scan('0);
    repeat (8)  do_scan(16'h0200);               // reset mid-hold, key kept down
    do_reset();
    repeat (6)  do_scan(16'h0200);
    repeat (5)  do_scan('0);

    for (int p = 0; p < 40; p++) begin
      logic [15:0] s;
      int          kind, len;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       s = '0;
        3:       s = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        default: s = 16'(1) << $urandom_range(0, 15);
      endcase
      len = int'($urandom_range(1, 6));
      for (int j = 0; j < len; j++) begin
        if (kind != 0 && $urandom_range(0, 7) == 0) do_scan(s ^ (16'(1) << $urandom_range(0, 15)));
        else                                        do_scan(s);
      end
    end

    repeat (DEB + 2) do_scan('0);
    repeat (4) @(negedge clk);
    check("events_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
